// File: rtl/refund_dispenser.sv
// rtl/refund_dispenser.sv - greedy two-denomination refund dispenser with jam timeout
module refund_dispenser #(
    parameter int MONEY_WIDTH    = 8,
    parameter int NOTE_HIGH      = 20,
    parameter int NOTE_LOW       = 10,
    parameter int COUNT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic [MONEY_WIDTH-1:0] inputMoney,
    input  logic                   cancelRequest,
    input  logic                   dispenseReady,
    output logic                   dispenseValid,
    output logic                   dispenseNoteHigh,
    output logic                   busy,
    output logic                   refundDone,
    output logic [COUNT_WIDTH-1:0] numberOfHighNotes,
    output logic [COUNT_WIDTH-1:0] numberOfLowNotes,
    output logic [MONEY_WIDTH-1:0] remainder,
    output logic                   jamFault
);

    // Stall counter only needs to count up to TIMEOUT_CYCLES-1; the edge that
    // would reach TIMEOUT_CYCLES is the one that declares the jam.
    localparam int STALL_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_WIDTH-1:0] STALL_LAST = STALL_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [MONEY_WIDTH-1:0] HIGH_VALUE = MONEY_WIDTH'(NOTE_HIGH);
    localparam logic [MONEY_WIDTH-1:0] LOW_VALUE  = MONEY_WIDTH'(NOTE_LOW);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    state_t                 state;
    logic [MONEY_WIDTH-1:0] balance;
    logic [STALL_WIDTH-1:0] stallCount;
    logic [MONEY_WIDTH-1:0] offeredValue;
    logic [MONEY_WIDTH-1:0] afterNote;

    // A note is only ever offered when balance covers it, so this never underflows.
    assign offeredValue = dispenseNoteHigh ? HIGH_VALUE : LOW_VALUE;
    assign afterNote    = balance - offeredValue;

    // Refund sequencer; all outputs are registered and precomputed for the next cycle.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state             <= IDLE;
            balance           <= '0;
            stallCount        <= '0;
            dispenseValid     <= 1'b0;
            dispenseNoteHigh  <= 1'b0;
            busy              <= 1'b0;
            refundDone        <= 1'b0;
            numberOfHighNotes <= '0;
            numberOfLowNotes  <= '0;
            remainder         <= '0;
            jamFault          <= 1'b0;
        end else begin
            refundDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancelRequest) begin
                        state             <= DISPENSE;
                        busy              <= 1'b1;
                        balance           <= inputMoney;
                        stallCount        <= '0;
                        numberOfHighNotes <= '0;
                        numberOfLowNotes  <= '0;
                        remainder         <= '0;
                        jamFault          <= 1'b0;
                        dispenseValid     <= (inputMoney >= LOW_VALUE);
                        dispenseNoteHigh  <= (inputMoney >= HIGH_VALUE);
                    end
                end
                DISPENSE: begin
                    if (!dispenseValid) begin
                        // Nothing dispensable left (zero or sub-note refund).
                        state      <= DONE;
                        refundDone <= 1'b1;
                        remainder  <= balance;
                    end else if (dispenseReady) begin
                        balance    <= afterNote;
                        stallCount <= '0;
                        if (dispenseNoteHigh) begin
                            if (numberOfHighNotes != COUNT_MAX)
                                numberOfHighNotes <= numberOfHighNotes + 1'b1;
                        end else begin
                            if (numberOfLowNotes != COUNT_MAX)
                                numberOfLowNotes <= numberOfLowNotes + 1'b1;
                        end
                        if (afterNote >= LOW_VALUE) begin
                            dispenseNoteHigh <= (afterNote >= HIGH_VALUE);
                        end else begin
                            // Last note taken: finish straight away so refundDone
                            // lands in the cycle right after it.
                            dispenseValid    <= 1'b0;
                            dispenseNoteHigh <= 1'b0;
                            state            <= DONE;
                            refundDone       <= 1'b1;
                            remainder        <= afterNote;
                        end
                    end else if (stallCount == STALL_LAST) begin
                        dispenseValid    <= 1'b0;
                        dispenseNoteHigh <= 1'b0;
                        jamFault         <= 1'b1;
                        state            <= DONE;
                        refundDone       <= 1'b1;
                        remainder        <= balance;
                    end else begin
                        stallCount <= stallCount + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/refund_dispenser.md
REFUND_DISPENSER -- requirements
Module: refund_dispenser

Interface
REQ-001 SHALL have parameter MONEY_WIDTH, default 8: width of money amounts.
REQ-002 SHALL have parameter NOTE_HIGH, default 20: value of the large note.
REQ-003 SHALL have parameter NOTE_LOW, default 10: value of the small note; NOTE_LOW < NOTE_HIGH.
REQ-004 SHALL have parameter COUNT_WIDTH, default 4: width of the note counters.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum stall cycles per note before a jam fault.
REQ-006 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port nReset  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port inputMoney  input  MONEY_WIDTH: credited amount to refund, unsigned.
REQ-009 SHALL have port cancelRequest  input  1: starts a refund when the block is idle.
REQ-010 SHALL have port dispenseReady  input  1: the note mechanism accepts the offered note.
REQ-011 SHALL have port dispenseValid  output  1: a note is offered.
REQ-012 SHALL have port dispenseNoteHigh  output  1: offered note type; 1 = NOTE_HIGH, 0 = NOTE_LOW.
REQ-013 SHALL have port busy  output  1: a refund is in progress.
REQ-014 SHALL have port refundDone  output  1: one-cycle pulse at the end of a refund.
REQ-015 SHALL have port numberOfHighNotes  output  COUNT_WIDTH: NOTE_HIGH notes dispensed in the current or last refund.
REQ-016 SHALL have port numberOfLowNotes  output  COUNT_WIDTH: NOTE_LOW notes dispensed in the current or last refund.
REQ-017 SHALL have port remainder  output  MONEY_WIDTH: amount that could not be dispensed.
REQ-018 SHALL have port jamFault  output  1: the last refund was aborted by timeout.

Function
REQ-019 SHALL implement the states IDLE, DISPENSE and DONE.
REQ-020 In IDLE, busy=0 and dispenseValid=0.
REQ-021 In IDLE, a clock edge with cancelRequest=1 SHALL load inputMoney into an internal balance, clear both counters, clear remainder, clear jamFault, clear the stall counter, and enter DISPENSE.
REQ-022 cancelRequest SHALL be ignored in DISPENSE and in DONE; inputMoney SHALL be sampled only when the refund is accepted.
REQ-023 In DISPENSE, busy=1.
REQ-024 In DISPENSE, dispenseValid=1 whenever balance >= NOTE_LOW.
REQ-025 In DISPENSE, dispenseNoteHigh=1 iff balance >= NOTE_HIGH (greedy: large notes first).
REQ-026 In DISPENSE with balance < NOTE_LOW, dispenseValid SHALL be 0 and the next state SHALL be DONE; a zero refund therefore reaches DONE one cycle after acceptance.
REQ-027 On an edge with dispenseValid and dispenseReady both 1, balance SHALL decrease by the offered note value, the matching counter SHALL increment (saturating, no wrap), and the stall counter SHALL clear.
REQ-028 While dispenseValid=1 and dispenseReady=0, dispenseValid and dispenseNoteHigh SHALL remain stable and the stall counter SHALL increment.
REQ-029 When the stall counter reaches TIMEOUT_CYCLES, the block SHALL drop dispenseValid, set jamFault (held until the next accepted refund), and enter DONE with balance unchanged.
REQ-030 In DONE, for exactly one cycle, refundDone=1, busy=1 and remainder=balance; the next state SHALL be IDLE.
REQ-031 Counters, remainder and jamFault SHALL hold their values in IDLE until the next accepted refund.
REQ-032 Latency: with dispenseReady tied 1, the first note is offered in the cycle after acceptance, one note is dispensed per cycle, and refundDone follows the cycle after the last note.
REQ-033 All subtraction SHALL be performed at MONEY_WIDTH with no underflow; the balance is never below 0.

Reset
REQ-034 When nReset=0, the block SHALL asynchronously enter IDLE and drive all outputs and internal registers to 0.
REQ-035 An assertion of nReset mid-refund SHALL drop dispenseValid immediately, discard the refund, and generate no refundDone.
REQ-036 Release of nReset SHALL be sampled synchronously; the first accepted refund is on the first edge after release with cancelRequest=1.

Verification
REQ-037 inputMoney=30, cancelRequest pulse, dispenseReady=1 -> high note in cycle 1, low note in cycle 2, refundDone in cycle 3, counts 1/1, remainder 0.
REQ-038 inputMoney=0 -> no dispenseValid, refundDone in cycle 2, counts 0/0, remainder 0.
REQ-039 inputMoney=45, dispenseReady low for 3 cycles on the first note -> valid/type held stable, final counts 2/0, remainder 5, jamFault 0.
REQ-040 inputMoney=45, dispenseReady=0 permanently -> jamFault=1 after 255 stall cycles, refundDone pulse, counts 0/0, remainder 45.
REQ-041 cancelRequest with inputMoney=20 while busy refunding 30 -> ignored; outcome identical to REQ-037.
REQ-042 nReset low during the second note of a 30 refund -> all outputs 0 at once, no refundDone, IDLE after release.
